// File: rtl/uart_agent.sv
// -----------------------------------------------------------------------------
// uart_agent
//   Clocked UART host agent. The transmitter serialises bytes onto
//   dut_uart_rxd; the receiver deserialises frames arriving on dut_uart_txd.
//   Bit timing for both directions comes from one integer divider (CLK_DIV
//   clk cycles per bit). TX and RX are fully independent.
//
// Parameters
//   CLK_DIV    clk cycles per bit (>= 4)
//   DATA_BITS  data bits per frame (5..8), LSB first
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   tx_data         byte to send
//   tx_valid        tx_data valid
//   tx_ready        agent can accept a byte
//   dut_uart_rxd    serial line to the DUT (idle high, registered)
//   dut_uart_txd    serial line from the DUT (asynchronous)
//   rx_data         last received data
//   rx_valid        one-cycle strobe: rx_data / error flags updated
//   rx_parity_err   parity mismatch on the frame just strobed
//   rx_frame_err    first stop bit sampled low on the frame just strobed
//   tx_state_dbg    TX FSM state (0 idle, 1 start, 2 data, 3 parity, 4 stop)
//   rx_state_dbg    RX FSM state (same encoding)
//
// Handshake: a byte transfers on the rising clk edge where tx_valid and
// tx_ready are both 1. tx_data is captured on that edge, tx_ready drops from
// the next cycle and rises again in the final stop cycle of the frame, so a
// source holding tx_valid high gets back-to-back frames with no idle gap.
// -----------------------------------------------------------------------------
module uart_agent #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 dut_uart_rxd,
  input  logic                 dut_uart_txd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic [2:0]           tx_state_dbg,
  output logic [2:0]           rx_state_dbg
);

  localparam int CW = $clog2(STOP_BITS * CLK_DIV);

  localparam logic [CW-1:0] BIT_LD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_LD = CW'(STOP_BITS * CLK_DIV - 1);
  localparam logic [2:0]    LAST    = 3'(DATA_BITS - 1);
  localparam logic          ODD     = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_t                tx_state, tx_state_n;
  logic [CW-1:0]         tx_cnt, tx_cnt_n;
  logic [2:0]            tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0]  tx_shift, tx_shift_n;
  logic                  tx_par, tx_par_n;
  logic                  tx_line, tx_line_n;
  logic                  tx_rdy, tx_rdy_n;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_line_n  = tx_line;
    tx_rdy_n   = tx_rdy;

    case (tx_state)
      S_IDLE: begin
        tx_line_n = 1'b1;
      end
      S_START: begin
        if (tx_cnt == '0) begin
          tx_state_n = S_DATA;
          tx_line_n  = tx_shift[0];
          tx_cnt_n   = BIT_LD;
          tx_idx_n   = '0;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt == '0) begin
          if (tx_idx == LAST) begin
            if (PARITY != 0) begin
              tx_state_n = S_PARITY;
              tx_line_n  = tx_par;
              tx_cnt_n   = BIT_LD;
            end else begin
              tx_state_n = S_STOP;
              tx_line_n  = 1'b1;
              tx_cnt_n   = STOP_LD;
            end
          end else begin
            // Shift register keeps the next bit at [1]; drive it now so the
            // line changes on the same edge the bit boundary is reached.
            tx_shift_n = tx_shift >> 1;
            tx_line_n  = tx_shift[1];
            tx_idx_n   = tx_idx + 3'd1;
            tx_cnt_n   = BIT_LD;
          end
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      S_PARITY: begin
        if (tx_cnt == '0) begin
          tx_state_n = S_STOP;
          tx_line_n  = 1'b1;
          tx_cnt_n   = STOP_LD;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      S_STOP: begin
        // Raise ready one edge early so it is visible in the last stop cycle.
        if (tx_cnt == CW'(1)) begin
          tx_rdy_n = 1'b1;
        end
        if (tx_cnt == '0) begin
          tx_state_n = S_IDLE;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      default: begin
        tx_state_n = S_IDLE;
        tx_line_n  = 1'b1;
        tx_rdy_n   = 1'b1;
      end
    endcase

    // tx_rdy is only high in IDLE or the final stop cycle, so acceptance
    // overrides whatever those states decided.
    if (tx_valid && tx_rdy) begin
      tx_state_n = S_START;
      tx_line_n  = 1'b0;
      tx_cnt_n   = BIT_LD;
      tx_shift_n = tx_data;
      tx_par_n   = (^tx_data) ^ ODD;
      tx_rdy_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
      tx_rdy   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx_line  <= tx_line_n;
      tx_rdy   <= tx_rdy_n;
    end
  end

  assign dut_uart_rxd = tx_line;
  assign tx_ready     = tx_rdy;
  assign tx_state_dbg = tx_state;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [1:0]            rx_sync;
  logic                  rxs;
  state_t                rx_state, rx_state_n;
  logic [CW-1:0]         rx_cnt, rx_cnt_n;
  logic [2:0]            rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0]  rx_shift, rx_shift_n;
  logic                  rx_pbit, rx_pbit_n;
  logic                  rx_armed, rx_armed_n;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_n;
  logic                  rx_valid_q, rx_valid_n;
  logic                  rx_perr_q, rx_perr_n;
  logic                  rx_ferr_q, rx_ferr_n;

  assign rxs = rx_sync[1];

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_pbit_n  = rx_pbit;
    rx_armed_n = rx_armed;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;
    rx_perr_n  = rx_perr_q;
    rx_ferr_n  = rx_ferr_q;

    case (rx_state)
      S_IDLE: begin
        // After a frame error with the line still low (break), the line must
        // be seen high once before a falling edge is accepted as a start.
        if (rx_armed && !rxs) begin
          rx_state_n = S_START;
          rx_cnt_n   = HALF_LD;
        end else if (rxs) begin
          rx_armed_n = 1'b1;
        end
      end
      S_START: begin
        if (rx_cnt == '0) begin
          if (rxs) begin
            rx_state_n = S_IDLE;   // glitch, no strobe
          end else begin
            rx_state_n = S_DATA;
            rx_cnt_n   = BIT_LD;
            rx_idx_n   = '0;
          end
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_n = {rxs, rx_shift[DATA_BITS-1:1]};
          rx_cnt_n   = BIT_LD;
          if (rx_idx == LAST) begin
            rx_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_idx_n = rx_idx + 3'd1;
          end
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      S_PARITY: begin
        if (rx_cnt == '0) begin
          rx_pbit_n  = rxs;
          rx_state_n = S_STOP;
          rx_cnt_n   = BIT_LD;
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      S_STOP: begin
        // Only the first stop bit is sampled; returning to IDLE here lets a
        // following start edge be caught during any remaining stop time.
        if (rx_cnt == '0) begin
          rx_state_n = S_IDLE;
          rx_valid_n = 1'b1;
          rx_data_n  = rx_shift;
          rx_perr_n  = (PARITY != 0) ? ((^rx_shift) ^ rx_pbit ^ ODD) : 1'b0;
          rx_ferr_n  = !rxs;
          rx_armed_n = rxs;
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      default: begin
        rx_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync    <= 2'b11;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_pbit    <= 1'b0;
      rx_armed   <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[0], dut_uart_txd};
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_idx     <= rx_idx_n;
      rx_shift   <= rx_shift_n;
      rx_pbit    <= rx_pbit_n;
      rx_armed   <= rx_armed_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
      rx_perr_q  <= rx_perr_n;
      rx_ferr_q  <= rx_ferr_n;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_state_dbg  = rx_state;

endmodule

// File: tb/tb_uart_agent.sv
// -----------------------------------------------------------------------------
// tb_uart_agent
//   Bench for uart_agent using three instances:
//     u_n  8N1, RX looped back from its own TX (timing, back-to-back, reset)
//     u_e  8E2, RX looped back (parity/two-stop loopback)
//     u_o  8O1, RX driven directly by the bench (errors, break, glitch)
//   Expected RX results ({frame_err, parity_err, data}) are queued when a
//   frame is driven and compared when the matching rx_valid strobe appears.
// -----------------------------------------------------------------------------
module tb_uart_agent;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // ---------------------------------------------------------------- signals
  logic [7:0] n_tx_data, e_tx_data, o_tx_data;
  logic       n_tx_valid, e_tx_valid, o_tx_valid;
  logic       n_tx_ready, e_tx_ready, o_tx_ready;
  logic       n_rxd, e_rxd, o_rxd;
  logic       o_line;
  logic [7:0] n_rx_data, e_rx_data, o_rx_data;
  logic       n_rx_valid, e_rx_valid, o_rx_valid;
  logic       n_perr, e_perr, o_perr;
  logic       n_ferr, e_ferr, o_ferr;
  logic [2:0] n_tx_st, e_tx_st, o_tx_st;
  logic [2:0] n_rx_st, e_rx_st, o_rx_st;

  logic [9:0] n_exp_q[$];
  logic [9:0] e_exp_q[$];
  logic [9:0] o_exp_q[$];
  logic [9:0] n_exp_v, e_exp_v, o_exp_v;
  int n_strobes = 0, e_strobes = 0, o_strobes = 0;

  uart_agent #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .tx_data(n_tx_data), .tx_valid(n_tx_valid),
    .tx_ready(n_tx_ready), .dut_uart_rxd(n_rxd), .dut_uart_txd(n_rxd),
    .rx_data(n_rx_data), .rx_valid(n_rx_valid), .rx_parity_err(n_perr),
    .rx_frame_err(n_ferr), .tx_state_dbg(n_tx_st), .rx_state_dbg(n_rx_st)
  );

  uart_agent #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_e (
    .clk(clk), .rst(rst), .tx_data(e_tx_data), .tx_valid(e_tx_valid),
    .tx_ready(e_tx_ready), .dut_uart_rxd(e_rxd), .dut_uart_txd(e_rxd),
    .rx_data(e_rx_data), .rx_valid(e_rx_valid), .rx_parity_err(e_perr),
    .rx_frame_err(e_ferr), .tx_state_dbg(e_tx_st), .rx_state_dbg(e_rx_st)
  );

  uart_agent #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o (
    .clk(clk), .rst(rst), .tx_data(o_tx_data), .tx_valid(o_tx_valid),
    .tx_ready(o_tx_ready), .dut_uart_rxd(o_rxd), .dut_uart_txd(o_line),
    .rx_data(o_rx_data), .rx_valid(o_rx_valid), .rx_parity_err(o_perr),
    .rx_frame_err(o_ferr), .tx_state_dbg(o_tx_st), .rx_state_dbg(o_rx_st)
  );

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (!rst && n_rx_valid) begin
      n_strobes++;
      checks++;
      assert (n_exp_q.size() != 0) else begin
        fails++;
        $error("FAIL n_rx_unexpected: observed strobe data 0x%0h expected no strobe", n_rx_data);
      end
      if (n_exp_q.size() != 0) begin
        n_exp_v = n_exp_q.pop_front();
        check("n_rx_frame", {22'd0, n_ferr, n_perr, n_rx_data}, {22'd0, n_exp_v});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && e_rx_valid) begin
      e_strobes++;
      checks++;
      assert (e_exp_q.size() != 0) else begin
        fails++;
        $error("FAIL e_rx_unexpected: observed strobe data 0x%0h expected no strobe", e_rx_data);
      end
      if (e_exp_q.size() != 0) begin
        e_exp_v = e_exp_q.pop_front();
        check("e_rx_frame", {22'd0, e_ferr, e_perr, e_rx_data}, {22'd0, e_exp_v});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && o_rx_valid) begin
      o_strobes++;
      checks++;
      assert (o_exp_q.size() != 0) else begin
        fails++;
        $error("FAIL o_rx_unexpected: observed strobe data 0x%0h expected no strobe", o_rx_data);
      end
      if (o_exp_q.size() != 0) begin
        o_exp_v = o_exp_q.pop_front();
        check("o_rx_frame", {22'd0, o_ferr, o_perr, o_rx_data}, {22'd0, o_exp_v});
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // Send one byte on u_n and check the line cycle-by-cycle over the frame.
  task automatic tx_frame_n(input logic [7:0] data);
    logic [9:0] frm;
    int ready_low;
    int bad;
    frm = {1'b1, data, 1'b0};
    ready_low = 0;
    @(negedge clk);
    n_tx_data  = data;
    n_tx_valid = 1'b1;
    n_exp_q.push_back({2'b00, data});
    @(posedge clk);
    #1 n_tx_valid = 1'b0;
    check("n_line_low_after_accept", {31'd0, n_rxd}, 32'd0);
    check("n_ready_low_after_accept", {31'd0, n_tx_ready}, 32'd0);
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (n_rxd !== frm[b]) bad++;
        if (n_tx_ready === 1'b0) ready_low++;
      end
      check($sformatf("n_frame_%0h_bit%0d_bad_cycles", data, b), bad, 0);
    end
    check("n_ready_low_cycles", ready_low, 159);
  endtask

  // Send one byte on u_e once it is ready (bounded wait).
  task automatic send_e(input logic [7:0] data);
    int t;
    t = 0;
    @(negedge clk);
    while (e_tx_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("e_ready_wait_in_budget", {31'd0, (t < 1000)}, 32'd1);
    e_tx_data  = data;
    e_tx_valid = 1'b1;
    e_exp_q.push_back({2'b00, data});
    @(posedge clk);
    #1 e_tx_valid = 1'b0;
  endtask

  task automatic drive_o_bit(input logic v);
    o_line = v;
    repeat (16) @(negedge clk);
  endtask

  // Drive an 8O1 frame into u_o; optionally invert parity / force stop low.
  task automatic drive_o(input logic [7:0] data, input logic flip_par, input logic stop_v);
    o_exp_q.push_back({~stop_v, flip_par, data});
    drive_o_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_o_bit(data[i]);
    drive_o_bit((~^data) ^ flip_par);
    drive_o_bit(stop_v);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [19:0] frm2;
    int bad;
    int second_at;
    int t;
    int s0;
    logic saw;

    rst = 1'b1;
    n_tx_data = '0; n_tx_valid = 1'b0;
    e_tx_data = '0; e_tx_valid = 1'b0;
    o_tx_data = '0; o_tx_valid = 1'b0;
    o_line = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_n_rxd", {31'd0, n_rxd}, 32'd1);
    check("rst_n_tx_ready", {31'd0, n_tx_ready}, 32'd1);
    check("rst_n_rx_data", {24'd0, n_rx_data}, 32'd0);
    check("rst_n_rx_valid", {31'd0, n_rx_valid}, 32'd0);
    check("rst_n_err_flags", {30'd0, n_ferr, n_perr}, 32'd0);
    check("rst_e_tx_ready", {31'd0, e_tx_ready}, 32'd1);
    check("rst_o_rxd", {31'd0, o_rxd}, 32'd1);
    check("rst_o_rx_state", {29'd0, o_rx_st}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic TX timing, 8N1, 0xC3
    tx_frame_n(8'hC3);

    // Back-to-back TX: valid held high across 0x55 then 0xAA
    @(negedge clk);
    n_tx_data  = 8'h55;
    n_tx_valid = 1'b1;
    n_exp_q.push_back({2'b00, 8'h55});
    n_exp_q.push_back({2'b00, 8'hAA});
    @(posedge clk);
    #1 n_tx_data = 8'hAA;
    frm2 = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
    bad = 0;
    second_at = 0;
    for (int i = 1; i <= 320; i++) begin
      @(negedge clk);
      if (n_rxd !== frm2[(i-1)/16]) bad++;
      if (n_tx_valid && n_tx_ready) begin
        second_at = i;
        @(posedge clk);
        #1 n_tx_valid = 1'b0;
      end
    end
    check("b2b_line_bad_cycles", bad, 0);
    check("b2b_second_accept_cycle", second_at, 160);
    @(negedge clk);
    check("b2b_idle_line", {31'd0, n_rxd}, 32'd1);
    check("b2b_idle_ready", {31'd0, n_tx_ready}, 32'd1);
    check("b2b_idle_tx_state", {29'd0, n_tx_st}, 32'd0);

    // Loopback with even parity and two stop bits
    send_e(8'h00);
    send_e(8'hFF);
    send_e(8'hA5);
    t = 0;
    while (e_exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("e_queue_drained", e_exp_q.size(), 0);
    check("e_strobe_count", e_strobes, 3);

    // Error injection on the odd-parity receiver
    repeat (5) @(negedge clk);
    drive_o(8'h3C, 1'b1, 1'b1);   // parity inverted
    drive_o(8'h96, 1'b0, 1'b1);   // clean frame
    drive_o(8'h5A, 1'b0, 1'b0);   // stop forced low, line stays low (break)
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (o_rx_st !== 3'd0) bad++;
    end
    check("break_rx_stays_idle_cycles", bad, 0);
    check("break_strobe_count", o_strobes, 3);
    drive_o_bit(1'b1);
    drive_o(8'h11, 1'b0, 1'b1);   // receiver re-armed after line high

    // Glitch rejection: 5-cycle low pulse
    repeat (20) @(negedge clk);
    s0 = o_strobes;
    saw = 1'b0;
    o_line = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_rx_st !== 3'd0) saw = 1'b1;
    end
    o_line = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_rx_st !== 3'd0) saw = 1'b1;
    end
    check("glitch_start_seen", {31'd0, saw}, 32'd1);
    check("glitch_no_strobe", o_strobes, s0);
    check("glitch_rx_idle", {29'd0, o_rx_st}, 32'd0);

    // Asynchronous reset during DATA bit 3 of 0xF0 (bit 3 is a 0)
    @(negedge clk);
    n_tx_data  = 8'hF0;
    n_tx_valid = 1'b1;
    @(posedge clk);
    #1 n_tx_valid = 1'b0;
    repeat (70) @(negedge clk);
    check("areset_line_low_before", {31'd0, n_rxd}, 32'd0);
    check("areset_ready_low_before", {31'd0, n_tx_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("areset_line_high", {31'd0, n_rxd}, 32'd1);
    check("areset_ready_high", {31'd0, n_tx_ready}, 32'd1);
    check("areset_rx_data_cleared", {24'd0, n_rx_data}, 32'd0);
    check("areset_tx_state_idle", {29'd0, n_tx_st}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tx_frame_n(8'h81);

    // Drain and final counts
    t = 0;
    while ((n_exp_q.size() + e_exp_q.size() + o_exp_q.size()) != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("all_queues_drained", n_exp_q.size() + e_exp_q.size() + o_exp_q.size(), 0);
    check("n_strobe_count", n_strobes, 4);
    check("o_strobe_count", o_strobes, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
